// File: rtl/kyber_pkg.sv
// Shared Kyber definitions: sizing constants, legal encode widths and the
// encoder FSM state encoding.
package kyber_pkg;

   localparam int N_COEFF = 256;
   localparam int CW      = 12;
   localparam int LANES   = 4;
   localparam int OW      = 64;
   localparam int ACC_W   = OW + LANES * CW;

   localparam logic [3:0] D1  = 4'd1;
   localparam logic [3:0] D4  = 4'd4;
   localparam logic [3:0] D5  = 4'd5;
   localparam logic [3:0] D10 = 4'd10;
   localparam logic [3:0] D11 = 4'd11;
   localparam logic [3:0] D12 = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PACK,
      ST_DRAIN,
      ST_DONE
   } enc_state_t;

   // Any width Kyber does not use is treated as full 12-bit coefficients.
   function automatic logic [3:0] legal_d(input logic [3:0] d);
      case (d)
         D1, D4, D5, D10, D11, D12: legal_d = d;
         default:                   legal_d = D12;
      endcase
   endfunction

endpackage

// File: rtl/encode_compact.sv
// Squeezes one 4-lane beat down to a contiguous 4d-bit chunk: each lane keeps
// its low d bits and lane k lands at bit offset k*d, right-aligned.
module encode_compact
   import kyber_pkg::*;
(
   input  logic [LANES*CW-1:0] i_beat,
   input  logic [3:0]          i_d,
   output logic [LANES*CW-1:0] o_chunk
);

   logic [CW-1:0] mask;
   logic [CW-1:0] lane;

   // Mask every lane to d bits and pack the lanes back to back.
   always_comb begin
      mask    = ~(12'hFFF << i_d);
      lane    = '0;
      o_chunk = '0;
      for (int k = 0; k < LANES; k++) begin
         lane    = i_beat[k*CW +: CW] & mask;
         o_chunk = o_chunk | ({{(LANES*CW-CW){1'b0}}, lane} << (k * int'(i_d)));
      end
   end

endmodule

// File: rtl/encode.sv
// ByteEncode_d: packs a 256-coefficient stream (4 lanes per beat) into
// contiguous little-endian 64-bit words. The accumulator holds up to one full
// word plus one beat so an input and an output transfer can share an edge.
module encode
   import kyber_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [3:0]    i_d,
   input  logic [47:0]   i_coeffs,
   input  logic          i_coeffs_valid,
   output logic          o_coeffs_ready,
   output logic [63:0]   o_obytes,
   output logic          o_obytes_valid,
   input  logic          i_obytes_ready,
   output logic          o_done
);

   localparam logic [6:0] LAST_BEAT = 7'(N_COEFF / LANES - 1);

   enc_state_t         state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [6:0]         fill_q, fill_d;
   logic [6:0]         beat_q, beat_d;
   logic [5:0]         words_q, words_d;
   logic [3:0]         dlat_q, dlat_d;

   logic [3:0]         d_eff;
   logic [47:0]        chunk;
   logic               in_xfer;
   logic               out_xfer;
   logic [ACC_W-1:0]   acc_base;
   logic [6:0]         fill_base;
   logic [5:0]         word_target;

   // In IDLE the incoming beat carries the width to latch; afterwards only
   // the latched width matters.
   assign d_eff       = (state_q == ST_IDLE) ? legal_d(i_d) : dlat_q;
   assign word_target = {dlat_q, 2'b00};

   assign o_obytes_valid = (fill_q >= 7'd64);
   assign o_obytes       = acc_q[63:0];
   assign o_done         = (state_q == ST_DONE);
   assign out_xfer       = o_obytes_valid & i_obytes_ready;
   assign o_coeffs_ready = ((state_q == ST_IDLE) || (state_q == ST_PACK)) &&
                           ((fill_q < 7'd64) || out_xfer);
   assign in_xfer        = i_coeffs_valid & o_coeffs_ready;

   encode_compact u_compact (
      .i_beat  (i_coeffs),
      .i_d     (d_eff),
      .o_chunk (chunk)
   );

   // Retire the outgoing word first, then append the new chunk at the
   // resulting fill point so simultaneous transfers lose nothing.
   always_comb begin
      acc_base  = out_xfer ? (acc_q >> OW) : acc_q;
      fill_base = out_xfer ? (fill_q - 7'd64) : fill_q;
      acc_d     = acc_base;
      fill_d    = fill_base;
      if (in_xfer) begin
         acc_d  = acc_base | ({{OW{1'b0}}, chunk} << fill_base);
         fill_d = fill_base + {1'b0, d_eff, 2'b00};
      end
   end

   // Sequencing: count beats in, count words out, pulse done once per polynomial.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      words_d = out_xfer ? (words_q + 6'd1) : words_q;
      dlat_d  = dlat_q;
      case (state_q)
         ST_IDLE: begin
            if (in_xfer) begin
               dlat_d  = legal_d(i_d);
               beat_d  = 7'd1;
               words_d = 6'd0;
               state_d = ST_PACK;
            end
         end
         ST_PACK: begin
            if (in_xfer) begin
               beat_d = beat_q + 7'd1;
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (out_xfer && ((words_q + 6'd1) == word_target)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            beat_d  = 7'd0;
            words_d = 6'd0;
            dlat_d  = 4'd0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All state registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         fill_q  <= '0;
         beat_q  <= '0;
         words_q <= '0;
         dlat_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         beat_q  <= beat_d;
         words_q <= words_d;
         dlat_q  <= dlat_d;
      end
   end

endmodule

// File: tb/tb_encode.sv
// Bench for encode: a bit-list model of ByteEncode_d produces the expected
// word stream; a single negedge process compares every accepted word, the
// done pulse and output hold-while-stalled behaviour.
module tb_encode;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [3:0]  i_d = 4'd0;
   logic [47:0] i_coeffs = '0;
   logic        i_coeffs_valid = 1'b0;
   logic        o_coeffs_ready;
   logic [63:0] o_obytes;
   logic        o_obytes_valid;
   logic        i_obytes_ready = 1'b1;
   logic        o_done;

   int          checks = 0;
   int          passes = 0;
   logic [63:0] exp_q[$];
   logic [11:0] coeffs[256];
   int          words_rx = 0;
   int          done_cnt = 0;
   logic        expect_done = 1'b0;
   logic        prev_stall = 1'b0;
   logic        poly_live = 1'b0;
   logic [63:0] prev_word = '0;
   logic [63:0] first_word = '0;
   bit          rand_ready = 1'b0;
   int          stalls;
   int          start_done;

   always #5 i_clk = ~i_clk;

   encode dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_d            (i_d),
      .i_coeffs       (i_coeffs),
      .i_coeffs_valid (i_coeffs_valid),
      .o_coeffs_ready (o_coeffs_ready),
      .o_obytes       (o_obytes),
      .o_obytes_valid (o_obytes_valid),
      .i_obytes_ready (i_obytes_ready),
      .o_done         (o_done)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: got 0x%016h, required 0x%016h", name, act, req);
   endtask

   function automatic int effD(input int d);
      if (d == 1 || d == 4 || d == 5 || d == 10 || d == 11 || d == 12) return d;
      return 12;
   endfunction

   // Model: concatenate the low d bits of every coefficient, cut into 64-bit words.
   task automatic buildModel(input int d);
      logic        bits[$];
      logic [63:0] w;
      exp_q.delete();
      for (int c = 0; c < 256; c++)
         for (int b = 0; b < d; b++)
            bits.push_back(coeffs[c][b]);
      for (int i = 0; i < bits.size() / 64; i++) begin
         w = '0;
         for (int b = 0; b < 64; b++) w[b] = bits[i*64 + b];
         exp_q.push_back(w);
      end
   endtask

   // Downstream ready: always high, or a fair coin each cycle.
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         i_obytes_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard: every cycle out of reset.
   always @(negedge i_clk) begin
      if (i_rst) begin
         prev_stall  = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("hold_valid", 64'(o_obytes_valid), 64'd1);
            checkOutput("hold_data", o_obytes, prev_word);
         end
         checkOutput("done_pulse", 64'(o_done), 64'(expect_done));
         expect_done = 1'b0;
         if (o_done) done_cnt++;
         if (o_obytes_valid && i_obytes_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("extra_word", 64'(o_obytes_valid), 64'd0);
            end else begin
               checkOutput("word", o_obytes, exp_q.pop_front());
               words_rx++;
               if (words_rx == 1) first_word = o_obytes;
               if (exp_q.size() == 0 && poly_live) expect_done = 1'b1;
            end
         end
         prev_stall = o_obytes_valid && !i_obytes_ready;
         prev_word  = o_obytes;
      end
   end

   // Drive nbeats beats of coeffs[]; i_d is d_in on beat 0 and noise afterwards.
   task automatic applyStimulus(input int d_in, input int nbeats, input int gap_at, output int n_stall);
      int idx = 0;
      int cyc = 0;
      int gap_left = 3;
      n_stall = 0;
      while (idx < nbeats && cyc < 4000) begin
         @(posedge i_clk);
         #1;
         cyc++;
         if (idx == gap_at && gap_left > 0) begin
            i_coeffs_valid = 1'b0;
            gap_left--;
         end else begin
            i_coeffs_valid = 1'b1;
            for (int k = 0; k < 4; k++) i_coeffs[k*12 +: 12] = coeffs[idx*4 + k];
            i_d = (idx == 0) ? 4'(d_in) : 4'($urandom_range(0, 15));
         end
         @(negedge i_clk);
         if (i_coeffs_valid) begin
            if (o_coeffs_ready) idx++;
            else n_stall++;
         end
      end
      @(posedge i_clk);
      #1;
      i_coeffs_valid = 1'b0;
      checkOutput("beats_sent", 64'(idx), 64'(nbeats));
   endtask

   task automatic runPoly(input int d_in, input int exp_words, input string tag, input int gap_at);
      int cyc = 0;
      words_rx   = 0;
      poly_live  = 1'b1;
      start_done = done_cnt;
      applyStimulus(d_in, 64, gap_at, stalls);
      while (done_cnt == start_done && cyc < 3000) begin
         @(negedge i_clk);
         cyc++;
      end
      repeat (3) @(negedge i_clk);
      checkOutput({tag, "_done_cnt"}, 64'(done_cnt - start_done), 64'd1);
      checkOutput({tag, "_words"}, 64'(words_rx), 64'(exp_words));
      checkOutput({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      poly_live = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state.
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      checkOutput("rst_valid", 64'(o_obytes_valid), 64'd0);
      checkOutput("rst_obytes", o_obytes, 64'd0);
      checkOutput("rst_done", 64'(o_done), 64'd0);
      checkOutput("rst_ready", 64'(o_coeffs_ready), 64'd1);

      // d=1, all ones.
      foreach (coeffs[i]) coeffs[i] = 12'h001;
      buildModel(1);
      checkOutput("model_d1_w0", exp_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
      runPoly(1, 4, "d1", -1);

      // d=12, repeating 1,2,3,4 lanes; stream must never stall.
      foreach (coeffs[i]) coeffs[i] = 12'(i % 4 + 1);
      buildModel(12);
      checkOutput("model_d12_w0", exp_q[0], 64'h2001_0040_0300_2001);
      runPoly(12, 48, "d12", -1);
      checkOutput("d12_first_word", first_word, 64'h2001_0040_0300_2001);
      checkOutput("d12_no_stall", 64'(stalls), 64'd0);

      // d=4 masking.
      foreach (coeffs[i]) coeffs[i] = 12'hFFA;
      buildModel(4);
      checkOutput("model_d4_w15", exp_q[15], 64'hAAAA_AAAA_AAAA_AAAA);
      runPoly(4, 16, "d4", -1);
      checkOutput("d4_first_word", first_word, 64'hAAAA_AAAA_AAAA_AAAA);

      // d=11 random data, random backpressure, input gap.
      rand_ready = 1'b1;
      foreach (coeffs[i]) coeffs[i] = 12'($urandom);
      buildModel(11);
      runPoly(11, 44, "d11", 10);

      // Abort a d=10 polynomial by reset after 20 beats.
      foreach (coeffs[i]) coeffs[i] = 12'($urandom);
      buildModel(10);
      words_rx   = 0;
      start_done = done_cnt;
      applyStimulus(10, 20, -1, stalls);
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      exp_q.delete();
      @(negedge i_clk);
      checkOutput("midrst_valid", 64'(o_obytes_valid), 64'd0);
      checkOutput("midrst_ready", 64'(o_coeffs_ready), 64'd1);
      repeat (10) @(negedge i_clk);
      checkOutput("midrst_no_done", 64'(done_cnt - start_done), 64'd0);

      // Fresh d=5 polynomial.
      foreach (coeffs[i]) coeffs[i] = 12'($urandom);
      buildModel(5);
      runPoly(5, 20, "d5", -1);

      // Illegal d=7 behaves as d=12; later i_d noise ignored.
      foreach (coeffs[i]) coeffs[i] = 12'($urandom);
      buildModel(effD(7));
      runPoly(7, 48, "d7", -1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
